// File: rtl/data_mem_pipe_pkg.sv
// Shared types and helpers for the pipelined data memory.
package data_mem_pipe_pkg;

    // Controller state: clearing the array after reset, or serving requests.
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Width of the saturating fault counter.
    localparam int ERR_CNT_W = 16;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

    // Number of byte lanes in a data word.
    function automatic int be_width(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/data_mem_ram.sv
// Single-port synchronous RAM with per-byte write enables and registered read.
// No reset: contents are cleared by the controller's sweep, not by reset.
module data_mem_ram
    import data_mem_pipe_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    parameter  int AW     = 4,
    localparam int BE_W   = be_width(DATA_W)
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [BE_W-1:0]   be_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // Byte-lane write and registered read of the addressed word.
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_pipe.sv
// Pipelined word RAM front-end: post-reset clear sweep, address fault
// decode, fixed-latency in-order responses and a saturating fault counter.
module data_mem_pipe
    import data_mem_pipe_pkg::*;
#(
    parameter  int DATA_W         = 32,
    parameter  int DEPTH          = 4000,
    parameter  int ADDR_W         = 32,
    parameter  int RD_LAT         = 1,
    parameter  int CLEAR_ON_RESET = 1,
    localparam int BE_W           = be_width(DATA_W)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_wdata,
    input  logic [BE_W-1:0]      req_be,
    output logic                 rsp_valid,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err,
    output logic                 init_done,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int OFF_W  = clog2(BE_W);
    localparam int RAM_AW = clog2(DEPTH);

    typedef struct packed {
        logic              valid;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } rsp_t;

    state_e                state_q, state_d;
    logic [RAM_AW-1:0]     clr_cnt_q, clr_cnt_d;
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic                  s0_valid_q, s0_valid_d;
    logic                  s0_err_q, s0_err_d;
    logic                  s0_rd_q, s0_rd_d;

    logic [ADDR_W-1:0]     word_idx_s;
    logic                  misalign_s;
    logic                  range_err_s;
    logic                  fault_s;
    logic                  accept_s;

    logic                  ram_en_s;
    logic                  ram_we_s;
    logic [RAM_AW-1:0]     ram_addr_s;
    logic [DATA_W-1:0]     ram_wdata_s;
    logic [BE_W-1:0]       ram_be_s;
    logic [DATA_W-1:0]     ram_rdata_s;

    rsp_t                  rsp_s;
    rsp_t                  rsp_out_s;

    // Address decode: word index, alignment and range faults, acceptance.
    always_comb begin
        word_idx_s  = req_addr >> OFF_W;
        misalign_s  = (req_addr & ADDR_W'(BE_W - 1)) != '0;
        range_err_s = word_idx_s >= ADDR_W'(DEPTH);
        fault_s     = misalign_s || range_err_s;
        accept_s    = req_valid && (state_q == ST_RUN);
    end

    // Controller next state: sweep every word once, then serve requests.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET == 0) begin
                    state_d = ST_RUN;
                end else if (clr_cnt_q == RAM_AW'(DEPTH - 1)) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + RAM_AW'(1);
                end
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d   = ST_INIT;
                clr_cnt_d = '0;
            end
        endcase
    end

    // RAM port steering: zero-fill during the sweep, otherwise the request.
    // Faulted requests never touch the array, so nothing aliases or wraps.
    always_comb begin
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_addr_s  = '0;
        ram_wdata_s = '0;
        ram_be_s    = '0;
        if ((state_q == ST_INIT) && (CLEAR_ON_RESET != 0)) begin
            ram_en_s   = 1'b1;
            ram_we_s   = 1'b1;
            ram_addr_s = clr_cnt_q;
            ram_be_s   = '1;
        end else if (accept_s && !fault_s) begin
            ram_en_s    = 1'b1;
            ram_we_s    = req_we;
            ram_addr_s  = word_idx_s[RAM_AW-1:0];
            ram_wdata_s = req_wdata;
            ram_be_s    = req_be;
        end else begin
            ram_en_s = 1'b0;
        end
    end

    // First response stage alongside the RAM read, plus fault counting.
    always_comb begin
        s0_valid_d = accept_s;
        s0_err_d   = accept_s && fault_s;
        s0_rd_d    = accept_s && !req_we && !fault_s;
        err_cnt_d  = err_cnt_q;
        if (accept_s && fault_s && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // State, sweep counter, fault counter and first response stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            clr_cnt_q  <= '0;
            err_cnt_q  <= '0;
            s0_valid_q <= 1'b0;
            s0_err_q   <= 1'b0;
            s0_rd_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            clr_cnt_q  <= clr_cnt_d;
            err_cnt_q  <= err_cnt_d;
            s0_valid_q <= s0_valid_d;
            s0_err_q   <= s0_err_d;
            s0_rd_q    <= s0_rd_d;
        end
    end

    data_mem_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en_s),
        .we_i    (ram_we_s),
        .addr_i  (ram_addr_s),
        .wdata_i (ram_wdata_s),
        .be_i    (ram_be_s),
        .rdata_o (ram_rdata_s)
    );

    // Assemble the response; read data only for non-faulted reads.
    always_comb begin
        rsp_s.valid = s0_valid_q;
        rsp_s.err   = s0_err_q;
        if (s0_rd_q) begin
            rsp_s.rdata = ram_rdata_s;
        end else begin
            rsp_s.rdata = '0;
        end
    end

    generate
        if (RD_LAT == 1) begin : g_lat1
            assign rsp_out_s = rsp_s;
        end else begin : g_latn
            rsp_t dly_q [RD_LAT-1];

            // Extra response delay stages, flushed by reset.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < RD_LAT - 1; i++) begin
                        dly_q[i] <= '0;
                    end
                end else begin
                    dly_q[0] <= rsp_s;
                    for (int i = 1; i < RD_LAT - 1; i++) begin
                        dly_q[i] <= dly_q[i-1];
                    end
                end
            end

            assign rsp_out_s = dly_q[RD_LAT-2];
        end
    endgenerate

    assign rsp_valid = rsp_out_s.valid;
    assign rsp_err   = rsp_out_s.err;
    assign rsp_rdata = rsp_out_s.rdata;
    assign req_ready = (state_q == ST_RUN);
    assign init_done = (state_q == ST_RUN);
    assign err_cnt   = err_cnt_q;

endmodule
